simon_playback_sequencer: RTL and testbench

Sequences the pattern-memory datapath during the PLAYBACK phase of the Simon game. On a start pulse it reads patterns 0..seq_len-1 from the synchronous pattern RAM and shows each one on the game LEDs for HOLD_CYCLES cycles, followed by GAP_CYCLES blank cycles. When the last gap ends it pulses done. The Simon control FSM issues start when it enters PLAYBACK and waits for done before moving to REPEAT, so the controller no longer has to pace the display itself.

---
 rtl/simon_pkg.sv | 23 ++
 rtl/simon_playback_sequencer_if.sv | 14 +
 rtl/simon_phase_timer.sv | 28 ++
 rtl/simon_playback_sequencer.sv | 148 ++++++++++++++
 tb/tb_simon_playback_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared Simon game definitions: pattern width, playback FSM states and the
// LED mode codes used by the Simon control FSM.
package simon_pkg;

  localparam int PAT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    SHOW,
    GAP,
    DONE
  } play_state_t;

  typedef enum logic [1:0] {
    LED_MODE_OFF,
    LED_MODE_PATTERN,
    LED_MODE_ECHO,
    LED_MODE_FAIL
  } led_mode_t;

endpackage

// File: rtl/simon_playback_sequencer_if.sv
// Pattern RAM read port: the sequencer is the master, the RAM the slave.
interface simon_playback_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int PAT_W  = 4
);

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PAT_W-1:0]  mem_rd_data;

  modport master (output mem_rd_en, output mem_addr, input mem_rd_data);
  modport slave  (input mem_rd_en, input mem_addr, output mem_rd_data);

endinterface

// File: rtl/simon_phase_timer.sv
// Loadable down-counter with a zero flag, shared by the SHOW and GAP phases.
module simon_phase_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/simon_playback_sequencer.sv
// Simon PLAYBACK phase: reads patterns 0..seq_len-1 from the pattern RAM,
// shows each for HOLD_CYCLES then blanks for GAP_CYCLES, and pulses done.
module simon_playback_sequencer #(
  parameter int          ADDR_W      = 6,
  parameter int          PAT_W       = simon_pkg::PAT_W,
  parameter int unsigned HOLD_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 2500000,
  parameter int          CNT_W       = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [ADDR_W:0]             seq_len,
  simon_playback_sequencer_if.master  mem,
  output logic [PAT_W-1:0]            pattern_leds,
  output logic [ADDR_W-1:0]           step_idx,
  output logic                        busy,
  output logic                        done
);

  import simon_pkg::*;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W:0]  LEN_ONE   = (ADDR_W+1)'(1);

  play_state_t       state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] idx;
  logic              last_step;

  logic              t_load;
  logic [CNT_W-1:0]  t_val;
  logic              t_dec;
  logic              t_zero;

  // Compare at ADDR_W+1 bits so a full-depth length (2**ADDR_W) ends on the
  // top address without idx ever overflowing.
  assign last_step = ({1'b0, idx} == (len - LEN_ONE));
  assign step_idx  = idx;

  // Timer control decoded from state: HOLD loads on data capture, GAP loads
  // as SHOW expires; otherwise count down while in either phase.
  always_comb begin
    t_load = 1'b0;
    t_val  = GAP_LOAD;
    t_dec  = 1'b0;
    if (state == WAIT_DATA) begin
      t_load = 1'b1;
      t_val  = HOLD_LOAD;
    end else if ((state == SHOW) && t_zero) begin
      t_load = 1'b1;
    end else if ((state == SHOW) || (state == GAP)) begin
      t_dec  = 1'b1;
    end
  end

  simon_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  // Playback FSM with registered RAM strobe, LED drive, busy and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      len           <= '0;
      idx           <= '0;
      mem.mem_rd_en <= 1'b0;
      mem.mem_addr  <= '0;
      pattern_leds  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else if (abort) begin
      state         <= IDLE;
      mem.mem_rd_en <= 1'b0;
      pattern_leds  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            len  <= seq_len;
            busy <= 1'b1;
            if (seq_len != '0) begin
              idx           <= '0;
              mem.mem_rd_en <= 1'b1;
              mem.mem_addr  <= '0;
              state         <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        FETCH: begin
          mem.mem_rd_en <= 1'b0;
          state         <= WAIT_DATA;
        end
        WAIT_DATA: begin
          pattern_leds <= mem.mem_rd_data;
          state        <= SHOW;
        end
        SHOW: begin
          if (t_zero) begin
            pattern_leds <= '0;
            state        <= GAP;
          end
        end
        GAP: begin
          if (t_zero) begin
            if (last_step) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx           <= idx + ADDR_W'(1);
              mem.mem_rd_en <= 1'b1;
              mem.mem_addr  <= idx + ADDR_W'(1);
              state         <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem.mem_rd_en <= 1'b0;
          pattern_leds  <= '0;
          busy          <= 1'b0;
          done          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Directed bench for simon_playback_sequencer with HOLD=3, GAP=2 (P=7).
module tb_simon_playback_sequencer;

  localparam int ADDR_W = 6;
  localparam int PAT_W  = 4;
  localparam int HOLD   = 3;
  localparam int GAPC   = 2;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   seq_len;
  logic [PAT_W-1:0]  leds;
  logic [ADDR_W-1:0] step_idx;
  logic              busy;
  logic              done;

  logic              s_start;
  logic              s_abort;
  logic [2:0]        s_seq_len;
  logic [PAT_W-1:0]  s_leds;
  logic [1:0]        s_step_idx;
  logic              s_busy;
  logic              s_done;

  simon_playback_sequencer_if #(.ADDR_W(ADDR_W), .PAT_W(PAT_W)) mem_bus ();
  simon_playback_sequencer_if #(.ADDR_W(2), .PAT_W(PAT_W)) s_bus ();

  simon_playback_sequencer #(
    .ADDR_W(ADDR_W), .PAT_W(PAT_W), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seq_len(seq_len),
    .mem(mem_bus), .pattern_leds(leds), .step_idx(step_idx), .busy(busy), .done(done)
  );

  simon_playback_sequencer #(
    .ADDR_W(2), .PAT_W(PAT_W), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC), .CNT_W(CNT_W)
  ) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .seq_len(s_seq_len),
    .mem(s_bus), .pattern_leds(s_leds), .step_idx(s_step_idx), .busy(s_busy), .done(s_done)
  );

  logic [PAT_W-1:0] ram [0:63];

  // Synchronous pattern RAMs: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_bus.mem_rd_en) mem_bus.mem_rd_data <= ram[mem_bus.mem_addr];
    if (s_bus.mem_rd_en)   s_bus.mem_rd_data   <= ram[{4'b0000, s_bus.mem_addr}];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            start;
    logic            abort;
    logic [ADDR_W:0] seq_len;
    logic [3:0]      leds;
    logic            rd_en;
    logic [5:0]      addr;
    logic            busy;
    logic            done;
  } vec_t;

  vec_t vec [24];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = '0;
    ram[0] = 4'b0001;
    ram[1] = 4'b0100;
    ram[2] = 4'b1000;
    ram[3] = 4'b0010;

    // Three-pattern playback, one record per cycle from the start cycle.
    for (int i = 0; i < 24; i++) begin
      vec[i].start   = (i == 0);
      vec[i].abort   = 1'b0;
      vec[i].seq_len = 7'd3;
      vec[i].leds    = (i >= 3  && i <= 5)  ? 4'b0001 :
                       (i >= 10 && i <= 12) ? 4'b0100 :
                       (i >= 17 && i <= 19) ? 4'b1000 : 4'b0000;
      vec[i].rd_en   = (i == 1 || i == 8 || i == 15);
      vec[i].addr    = (i == 1) ? 6'd0 : (i == 8) ? 6'd1 : 6'd2;
      vec[i].busy    = (i >= 1 && i <= 22);
      vec[i].done    = (i == 22);
    end

    rst = 1'b1; start = 1'b0; abort = 1'b0; seq_len = '0;
    s_start = 1'b0; s_abort = 1'b0; s_seq_len = '0;
    repeat (3) @(negedge clk);
    chk("reset leds", leds, 0);
    chk("reset rd_en", mem_bus.mem_rd_en, 0);
    chk("reset addr", mem_bus.mem_addr, 0);
    chk("reset step_idx", step_idx, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset small busy", s_busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: table-driven three-pattern playback.
    for (int i = 0; i < 24; i++) begin
      start = vec[i].start; abort = vec[i].abort; seq_len = vec[i].seq_len;
      chk($sformatf("t1 leds c%0d", i), leds, vec[i].leds);
      chk($sformatf("t1 rd_en c%0d", i), mem_bus.mem_rd_en, vec[i].rd_en);
      chk($sformatf("t1 busy c%0d", i), busy, vec[i].busy);
      chk($sformatf("t1 done c%0d", i), done, vec[i].done);
      if (vec[i].rd_en) chk($sformatf("t1 addr c%0d", i), mem_bus.mem_addr, vec[i].addr);
      @(negedge clk);
    end
    start = 1'b0;

    // Test 2: zero length goes straight to DONE.
    for (int i = 0; i < 4; i++) begin
      start = (i == 0); seq_len = '0;
      chk($sformatf("t2 busy c%0d", i), busy, (i == 1));
      chk($sformatf("t2 done c%0d", i), done, (i == 1));
      chk($sformatf("t2 rd_en c%0d", i), mem_bus.mem_rd_en, 0);
      @(negedge clk);
    end

    // abort together with start in IDLE: start is dropped.
    for (int i = 0; i < 4; i++) begin
      start = (i == 0); abort = (i == 0); seq_len = 7'd3;
      chk($sformatf("abort+start busy c%0d", i), busy, 0);
      chk($sformatf("abort+start rd_en c%0d", i), mem_bus.mem_rd_en, 0);
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;

    // Test 3: abort during SHOW of pattern 1.
    for (int i = 0; i < 31; i++) begin
      start = (i == 0); abort = (i == 11); seq_len = 7'd3;
      if (i == 11) begin
        chk("t3 leds before abort", leds, 4'b0100);
        chk("t3 busy before abort", busy, 1);
      end
      if (i == 12) begin
        chk("t3 busy after abort", busy, 0);
        chk("t3 leds after abort", leds, 0);
      end
      if (i >= 12) begin
        chk($sformatf("t3 done c%0d", i), done, 0);
        chk($sformatf("t3 rd_en c%0d", i), mem_bus.mem_rd_en, 0);
      end
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;

    // Test 4: start while busy is ignored; seq_len changes are not sampled.
    for (int i = 0; i < 24; i++) begin
      start = (i == 0 || i == 5); seq_len = (i < 5) ? 7'd3 : 7'd1;
      chk($sformatf("t4 done c%0d", i), done, (i == 22));
      chk($sformatf("t4 busy c%0d", i), busy, (i >= 1 && i <= 22));
      @(negedge clk);
    end
    for (int j = 0; j < 11; j++) begin
      start = (j == 0); seq_len = 7'd1;
      chk($sformatf("t4b done c%0d", j), done, (j == 8));
      chk($sformatf("t4b rd_en c%0d", j), mem_bus.mem_rd_en, (j == 1));
      @(negedge clk);
    end
    start = 1'b0;

    // Test 5: reset in the last GAP cycle of pattern 0.
    for (int i = 0; i < 9; i++) begin
      start = (i == 0); seq_len = 7'd3; rst = (i == 7);
      if (i == 7) chk("t5 busy in gap", busy, 1);
      if (i == 8) begin
        chk("t5 leds after rst", leds, 0);
        chk("t5 rd_en after rst", mem_bus.mem_rd_en, 0);
        chk("t5 addr after rst", mem_bus.mem_addr, 0);
        chk("t5 step_idx after rst", step_idx, 0);
        chk("t5 busy after rst", busy, 0);
        chk("t5 done after rst", done, 0);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      start = (j == 0); seq_len = 7'd1;
      chk($sformatf("t5b leds c%0d", j), leds, (j >= 3 && j <= 5) ? 4'b0001 : 4'b0000);
      chk($sformatf("t5b done c%0d", j), done, (j == 8));
      @(negedge clk);
    end
    start = 1'b0;

    // Test 6: full depth on the ADDR_W=2 instance.
    for (int i = 0; i < 32; i++) begin
      s_start = (i == 0); s_seq_len = 3'd4;
      chk($sformatf("t6 rd_en c%0d", i), s_bus.mem_rd_en,
          (i == 1 || i == 8 || i == 15 || i == 22));
      if (i == 1 || i == 8 || i == 15 || i == 22)
        chk($sformatf("t6 addr c%0d", i), s_bus.mem_addr, (i - 1) / 7);
      if (i == 24) chk("t6 leds pattern3", s_leds, 4'b0010);
      chk($sformatf("t6 done c%0d", i), s_done, (i == 29));
      @(negedge clk);
    end
    s_start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
